// File: rtl/fwd_hazard_unit_if.sv
// Execute-stage view of the forwarding/hazard unit: operand/destination info in, bypass controls and stall out.
// Pure wiring bundle; no state, no latency of its own.
interface fwd_hazard_unit_if #(
  parameter int REG_BITS = 3
);
  logic                ex_valid;
  logic [REG_BITS-1:0] ex_srcA;
  logic                ex_useA;
  logic [REG_BITS-1:0] ex_srcB;
  logic                ex_useB;
  logic                ex_regWrite;
  logic [REG_BITS-1:0] ex_dst;
  logic [1:0]          ex_wbSel;
  logic                forward_XX_A;
  logic                forward_XX_B;
  logic                forward_XM_A;
  logic                forward_XM_B;
  logic [1:0]          forward_XX_sel;
  logic [1:0]          forward_XM_sel;
  logic                stall;

  modport master (
    output ex_valid, ex_srcA, ex_useA, ex_srcB, ex_useB, ex_regWrite, ex_dst, ex_wbSel,
    input  forward_XX_A, forward_XX_B, forward_XM_A, forward_XM_B,
    input  forward_XX_sel, forward_XM_sel, stall
  );

  modport slave (
    input  ex_valid, ex_srcA, ex_useA, ex_srcB, ex_useB, ex_regWrite, ex_dst, ex_wbSel,
    output forward_XX_A, forward_XX_B, forward_XM_A, forward_XM_B,
    output forward_XX_sel, forward_XM_sel, stall
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Bypass select and load-use stall for execute, from the X/M and M/W destination records.
// Outputs are zero-latency combinational; stall holds IF/ID/EX for one cycle and injects a bubble.
// Optional perf counters (stall_count, fwd_count, perf_clr) exist only when FWD_PERF_EN is defined.
module fwd_hazard_unit #(
  parameter int REG_BITS = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  fwd_hazard_unit_if.slave  ex,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  fwd_count
);

  localparam logic [1:0] SEL_MEM = 2'b10;

  typedef struct packed {
    logic                wr;
    logic [REG_BITS-1:0] dst;
    logic [1:0]          sel;
  } rec_t;

  rec_t xm, mw, xm_next;

  logic xm_a, xm_b, mw_a, mw_b;
  logic stall_int;
  logic fxx_a, fxx_b, fxm_a, fxm_b;

  assign xm_a = ex.ex_valid & ex.ex_useA & xm.wr & (xm.dst == ex.ex_srcA);
  assign xm_b = ex.ex_valid & ex.ex_useB & xm.wr & (xm.dst == ex.ex_srcB);
  assign mw_a = ex.ex_valid & ex.ex_useA & mw.wr & (mw.dst == ex.ex_srcA);
  assign mw_b = ex.ex_valid & ex.ex_useB & mw.wr & (mw.dst == ex.ex_srcB);

  assign stall_int = (xm_a | xm_b) & (xm.sel == SEL_MEM);

  // An operand may hit M/W while its twin stalls on X/M, so the stall mask is needed on every flag.
  assign fxx_a = xm_a & (xm.sel != SEL_MEM) & ~stall_int;
  assign fxx_b = xm_b & (xm.sel != SEL_MEM) & ~stall_int;
  assign fxm_a = mw_a & ~xm_a & ~stall_int;
  assign fxm_b = mw_b & ~xm_b & ~stall_int;

  assign ex.forward_XX_A   = fxx_a;
  assign ex.forward_XX_B   = fxx_b;
  assign ex.forward_XM_A   = fxm_a;
  assign ex.forward_XM_B   = fxm_b;
  assign ex.forward_XX_sel = (fxx_a | fxx_b) ? xm.sel : 2'b00;
  assign ex.forward_XM_sel = (fxm_a | fxm_b) ? mw.sel : 2'b00;
  assign ex.stall          = stall_int;

  always_comb begin
    xm_next = '0;
    if (!stall_int) begin
      xm_next.wr  = ex.ex_valid & ex.ex_regWrite;
      xm_next.dst = ex.ex_dst;
      xm_next.sel = ex.ex_wbSel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      xm <= '0;
      mw <= '0;
    end else begin
      mw <= xm;
      xm <= xm_next;
    end
  end

`ifdef FWD_PERF_EN
  logic fwd_any;
  assign fwd_any = fxx_a | fxx_b | fxm_a | fxm_b;

  // Counters saturate at all-ones; clear beats increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else if (perf_clr) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (stall_int && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (fwd_any && !(&fwd_count))     fwd_count   <= fwd_count + 1'b1;
    end
  end
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_count     = '0;
  assign fwd_count       = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed test-plan sequence followed by randomized traffic, checked against an in-flight instruction list model.
module tb_fwd_hazard_unit;

  localparam int REG_BITS = 3;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             perf_clr;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] fwd_count;

  fwd_hazard_unit_if #(.REG_BITS(REG_BITS)) bif ();

  fwd_hazard_unit #(.REG_BITS(REG_BITS), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex          (bif),
    .perf_clr    (perf_clr),
    .stall_count (stall_count),
    .fwd_count   (fwd_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the two instructions ahead of execute, youngest first.
  typedef struct {
    bit wr;
    int dst;
    int sel;
  } ins_t;

  ins_t pipe [0:1];
  bit   e_stall, e_xxa, e_xxb, e_xma, e_xmb;
  int   e_xxsel, e_xmsel;
  int   m_stall_cnt, m_fwd_cnt;
  bit   last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int producer(input bit use_op, input int src);
    if (!(bif.ex_valid && use_op)) return -1;
    for (int k = 0; k < 2; k++)
      if (pipe[k].wr && pipe[k].dst == src) return k;
    return -1;
  endfunction

  task automatic predict();
    int a, b;
    bit ld;
    a = producer(bif.ex_useA, int'(bif.ex_srcA));
    b = producer(bif.ex_useB, int'(bif.ex_srcB));
    ld = (pipe[0].sel == 2);
    e_stall = (a == 0 && ld) || (b == 0 && ld);
    e_xxa = !e_stall && a == 0;
    e_xxb = !e_stall && b == 0;
    e_xma = !e_stall && a == 1;
    e_xmb = !e_stall && b == 1;
    e_xxsel = (e_xxa || e_xxb) ? pipe[0].sel : 0;
    e_xmsel = (e_xma || e_xmb) ? pipe[1].sel : 0;
  endtask

  task automatic check_model();
    predict();
    chk("stall",      32'(bif.stall),          32'(e_stall));
    chk("fwd_XX_A",   32'(bif.forward_XX_A),   32'(e_xxa));
    chk("fwd_XX_B",   32'(bif.forward_XX_B),   32'(e_xxb));
    chk("fwd_XM_A",   32'(bif.forward_XM_A),   32'(e_xma));
    chk("fwd_XM_B",   32'(bif.forward_XM_B),   32'(e_xmb));
    chk("fwd_XX_sel", 32'(bif.forward_XX_sel), 32'(e_xxsel));
    chk("fwd_XM_sel", 32'(bif.forward_XM_sel), 32'(e_xmsel));
    chk("stall_count", 32'(stall_count), 32'(m_stall_cnt));
    chk("fwd_count",   32'(fwd_count),   32'(m_fwd_cnt));
  endtask

  task automatic advance();
    ins_t n;
    int   sat;
    sat = (1 << CNT_W) - 1;
    if (!rst) begin
      pipe[0] = '{0, 0, 0};
      pipe[1] = '{0, 0, 0};
`ifdef FWD_PERF_EN
      m_stall_cnt = 0;
      m_fwd_cnt   = 0;
`endif
    end else begin
      n = '{0, 0, 0};
      if (!e_stall && bif.ex_valid && bif.ex_regWrite)
        n = '{1, int'(bif.ex_dst), int'(bif.ex_wbSel)};
      pipe[1] = pipe[0];
      pipe[0] = n;
`ifdef FWD_PERF_EN
      if (perf_clr) begin
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
      end else begin
        if (e_stall && m_stall_cnt < sat) m_stall_cnt++;
        if ((e_xxa || e_xxb || e_xma || e_xmb) && m_fwd_cnt < sat) m_fwd_cnt++;
      end
`endif
    end
    last_stall = e_stall;
  endtask

  task automatic drive(input bit v, input int sa, input bit ua, input int sb, input bit ub,
                       input bit wr, input int d, input int sel);
    bif.ex_valid    = v;
    bif.ex_srcA     = REG_BITS'(sa);
    bif.ex_useA     = ua;
    bif.ex_srcB     = REG_BITS'(sb);
    bif.ex_useB     = ub;
    bif.ex_regWrite = wr;
    bif.ex_dst      = REG_BITS'(d);
    bif.ex_wbSel    = 2'(sel);
  endtask

  task automatic settle();
    @(negedge clk);
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    pipe[0] = '{0, 0, 0};
    pipe[1] = '{0, 0, 0};
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
    last_stall  = 0;
    rst      = 1'b0;
    perf_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    settle();
    chk("reset_stall", 32'(bif.stall), 32'd0);
    chk("reset_fwd", 32'({bif.forward_XX_A, bif.forward_XX_B, bif.forward_XM_A, bif.forward_XM_B,
                           bif.forward_XX_sel, bif.forward_XM_sel}), 32'd0);
    tick();
    rst = 1'b1;

    // ADD r3 then SUB reading r3 on A
    drive(1, 0, 0, 0, 0, 1, 3, 3); step();
    drive(1, 3, 1, 5, 1, 1, 4, 3); settle();
    chk("tp1_XX_A", 32'(bif.forward_XX_A), 32'd1);
    chk("tp1_sel",  32'(bif.forward_XX_sel), 32'd3);
    chk("tp1_stall", 32'(bif.stall), 32'd0);
    tick();

    // ADD r3, unrelated, consumer B=r3
    drive(1, 0, 0, 0, 0, 1, 3, 3); step();
    drive(1, 6, 1, 6, 1, 1, 5, 3); step();
    drive(1, 7, 1, 3, 1, 0, 0, 0); settle();
    chk("tp2_XM_B", 32'(bif.forward_XM_B), 32'd1);
    chk("tp2_sel",  32'(bif.forward_XM_sel), 32'd3);
    tick();

    // LD r2 then consumer A=r2: one stall, then M/W forward of memory data
    drive(1, 0, 0, 0, 0, 1, 2, 2); step();
    drive(1, 2, 1, 7, 1, 1, 6, 3); settle();
    chk("tp3_stall1", 32'(bif.stall), 32'd1);
    chk("tp3_fwd_off", 32'({bif.forward_XX_A, bif.forward_XX_B, bif.forward_XM_A, bif.forward_XM_B}), 32'd0);
    tick();
    settle();
    chk("tp3_stall2", 32'(bif.stall), 32'd0);
    chk("tp3_XM_A",   32'(bif.forward_XM_A), 32'd1);
    chk("tp3_XM_sel", 32'(bif.forward_XM_sel), 32'd2);
    tick();

    // ADD r1, LBI r1, consumer A=B=r1: youngest writer wins
    drive(1, 0, 0, 0, 0, 1, 1, 3); step();
    drive(1, 0, 0, 0, 0, 1, 1, 0); step();
    drive(1, 1, 1, 1, 1, 0, 0, 0); settle();
    chk("tp4_XX_AB", 32'({bif.forward_XX_A, bif.forward_XX_B}), 32'd3);
    chk("tp4_XX_sel", 32'(bif.forward_XX_sel), 32'd0);
    chk("tp4_XM_off", 32'({bif.forward_XM_A, bif.forward_XM_B}), 32'd0);
    tick();

    // Reset asserted during a load-use stall
    drive(1, 0, 0, 0, 0, 1, 2, 2); step();
    drive(1, 2, 1, 0, 0, 1, 4, 3);
    rst = 1'b0;
    settle();
    chk("tp5_stall_pre", 32'(bif.stall), 32'd1);
    tick();
    rst = 1'b1;
    settle();
    chk("tp5_stall_post", 32'(bif.stall), 32'd0);
    chk("tp5_fwd_post", 32'({bif.forward_XX_A, bif.forward_XX_B, bif.forward_XM_A, bif.forward_XM_B,
                              bif.forward_XX_sel, bif.forward_XM_sel}), 32'd0);
    tick();

`ifdef FWD_PERF_EN
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    perf_clr = 1'b1; step();
    perf_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 1, 2, 2); step();
      drive(1, 2, 1, 0, 0, 0, 0, 0); step(); step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 1, 3, 3); step();
      drive(1, 3, 1, 0, 0, 0, 0, 0); step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("perf_stall_cnt", 32'(stall_count), 32'd3);
    chk("perf_fwd_cnt",   32'(fwd_count),   32'd5);
    perf_clr = 1'b1; tick();
    perf_clr = 1'b0; settle();
    chk("perf_clr_stall", 32'(stall_count), 32'd0);
    chk("perf_clr_fwd",   32'(fwd_count),   32'd0);
    tick();
`endif

    // Randomized traffic; upstream repeats its inputs after a stall cycle
    for (int i = 0; i < 600; i++) begin
      if (!last_stall)
        drive(($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 3));
      rst      = ($urandom_range(0, 49) != 0);
      perf_clr = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
